// File: rtl/multi_byte_adder_sequencer_pkg.sv
// Shared types and constants for the byte-serial adder sequencer.
// Optional subtract mode: ADDER_SEQ_SUBTRACT_EN.
package multi_byte_adder_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multi_byte_adder_sequencer_byte_cla_slice.sv
// Combinational 8-bit carry-lookahead slice.
// Every carry is a flat sum of generate/propagate products.
module byte_cla_slice
    import multi_byte_adder_sequencer_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              c_i,
    output logic [BYTE_W-1:0] sum_o,
    output logic              c_o
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;
    logic              pp;

    // Expand c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]c_i
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        c  = '0;
        pp = 1'b1;
        c[0] = c_i;
        for (int i = 1; i <= BYTE_W; i++) begin
            pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & pp);
                pp   = pp & p[j];
            end
            c[i] = c[i] | (pp & c_i);
        end
        sum_o = p ^ c[BYTE_W-1:0];
        c_o   = c[BYTE_W];
    end

endmodule

// File: rtl/multi_byte_adder_sequencer.sv
// Byte-serial multi-byte adder, LSB first, one CLA slice per cycle.
// Define ADDER_SEQ_SUBTRACT_EN to add the Sub_In (A-B) port.
module multi_byte_adder_sequencer
    import multi_byte_adder_sequencer_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                          Clk_In,
    input  logic                          Reset_n_In,
    input  logic                          Start_In,
    input  logic [BYTE_W*NUM_BYTES-1:0]   Data_A_In,
    input  logic [BYTE_W*NUM_BYTES-1:0]   Data_B_In,
    input  logic                          Carry_In,
`ifdef ADDER_SEQ_SUBTRACT_EN
    input  logic                          Sub_In,
`endif
    output logic                          Busy_Out,
    output logic                          Done_Out,
    output logic [BYTE_W*NUM_BYTES-1:0]   Sum_Out,
    output logic                          Carry_Out
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      work_q, work_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic [BYTE_W-1:0] sl_a;
    logic [BYTE_W-1:0] sl_b;
    logic [BYTE_W-1:0] sl_sum;
    logic              sl_co;
    logic [W-1:0]      b_cap;
    logic              c_cap;

    // Operand B and initial carry as captured on an accepted start
    always_comb begin
`ifdef ADDER_SEQ_SUBTRACT_EN
        b_cap = Sub_In ? ~Data_B_In : Data_B_In;
        c_cap = Sub_In ? 1'b1 : Carry_In;
`else
        b_cap = Data_B_In;
        c_cap = Carry_In;
`endif
    end

    // Select the byte currently being processed
    always_comb begin
        sl_a = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
        sl_b = b_q[BYTE_W*int'(idx_q) +: BYTE_W];
    end

    byte_cla_slice u_slice (
        .a_i   (sl_a),
        .b_i   (sl_b),
        .c_i   (carry_q),
        .sum_o (sl_sum),
        .c_o   (sl_co)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Start_In) begin
                    state_d = RUN;
                    a_d     = Data_A_In;
                    b_d     = b_cap;
                    carry_d = c_cap;
                    work_d  = '0;
                    idx_d   = '0;
                end
            end
            RUN: begin
                work_d[BYTE_W*int'(idx_q) +: BYTE_W] = sl_sum;
                carry_d = sl_co;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    sum_d   = work_d;
                    cout_d  = sl_co;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign Busy_Out  = (state_q == RUN);
    assign Done_Out  = (state_q == DONE);
    assign Sum_Out   = sum_q;
    assign Carry_Out = cout_q;

endmodule

// File: tb/tb_multi_byte_adder_sequencer.sv
// Scoreboard bench for multi_byte_adder_sequencer (NUM_BYTES = 4).
// Subtract vectors run when ADDER_SEQ_SUBTRACT_EN is defined.
module tb_multi_byte_adder_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] da;
    logic [W-1:0] db;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int compared;
    int mismatched;
    exp_t sb[$];

    multi_byte_adder_sequencer #(.NUM_BYTES(NB)) dut (
        .Clk_In     (clk),
        .Reset_n_In (rst_n),
        .Start_In   (start),
        .Data_A_In  (da),
        .Data_B_In  (db),
        .Carry_In   (cin),
`ifdef ADDER_SEQ_SUBTRACT_EN
        .Sub_In     (sub),
`endif
        .Busy_Out   (busy),
        .Done_Out   (done),
        .Sum_Out    (sum),
        .Carry_Out  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop one expectation per Done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got sum %0h expected none",
                         sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("carry", 64'(cout), 64'(e.carry));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic c,
                         input logic s,
                         input logic [W-1:0] es,
                         input logic ec);
        exp_t e;
        start = 1'b1;
        da    = a;
        db    = b;
        cin   = c;
        sub   = s;
        e.sum   = es;
        e.carry = ec;
        sb.push_back(e);
        tick();
        start = 1'b0;
        da    = W'($urandom);
        db    = W'($urandom);
        cin   = 1'b0;
        sub   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        start = 1'b0;
        da    = '0;
        db    = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_carry", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Carry ripples through every byte; latency checked
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0,
              32'h0000_0000, 1'b1);
        check("lat_busy0", 64'(busy), 64'd1);
        for (int k = 1; k < NB; k++) begin
            tick();
            check("lat_busy", 64'(busy), 64'd1);
            check("lat_nodone", 64'(done), 64'd0);
        end
        tick();
        check("lat_busy_end", 64'(busy), 64'd0);
        check("lat_done", 64'(done), 64'd1);
        wait_drain();

        issue(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
              32'h2345_678A, 1'b0);
        wait_drain();

        // Start during RUN is ignored; prior result held meanwhile
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0,
              32'h0000_0003, 1'b0);
        check("held_sum", 64'(sum), 64'h2345_678A);
        start = 1'b1;
        da    = 32'h0000_0009;
        db    = 32'h0000_0009;
        tick();
        start = 1'b0;
        check("held_busy", 64'(busy), 64'd1);
        wait_drain();

        // Start held through DONE restarts immediately
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
              32'h0001_0000, 1'b0);
        start = 1'b1;
        da    = 32'h0000_00FF;
        db    = 32'h0000_0001;
        begin
            exp_t e;
            e.sum   = 32'h0000_0100;
            e.carry = 1'b0;
            sb.push_back(e);
        end
        for (int i = 0; i < 10 && !done; i++) tick();
        check("b2b_done", 64'(done), 64'd1);
        tick();
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        wait_drain();

        // Reset in the middle of RUN aborts without Done
        issue(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0,
              32'h0, 1'b0);
        void'(sb.pop_back());
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_carry", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
              32'h0000_0000, 1'b1);
        wait_drain();

`ifdef ADDER_SEQ_SUBTRACT_EN
        issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1,
              32'hFFFF_FFFE, 1'b0);
        wait_drain();
        issue(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1,
              32'h0000_0002, 1'b1);
        wait_drain();
`endif

        for (int i = 0; i < 5; i++) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_byte_adder_sequencer.md
MULTI_BYTE_ADDER_SEQUENCER -- requirements
Module: multi_byte_adder_sequencer

Interface
REQ-001 Parameter: NUM_BYTES, 4, operand width in bytes (legal 2..16); W = 8*NUM_BYTES.
REQ-002 Clk_In  in  1  single clock; all state changes on the rising edge.
REQ-003 Reset_n_In  in  1  asynchronous, active-low reset.
REQ-004 Start_In  in  1  request a new addition; sampled only in IDLE or DONE.
REQ-005 Data_A_In  in  W  operand A; captured on accepted Start.
REQ-006 Data_B_In  in  W  operand B; captured on accepted Start.
REQ-007 Carry_In  in  1  initial carry; captured on accepted Start.
REQ-008 Busy_Out  out  1  high while in RUN.
REQ-009 Done_Out  out  1  one-cycle pulse when a result is valid.
REQ-010 Sum_Out  out  W  registered result; held until the next completion.
REQ-011 Carry_Out  out  1  registered final carry; held with Sum_Out.

Function
REQ-012 The block SHALL add A+B+Carry_In byte-serially, least significant byte first, using one 8-bit carry-lookahead slice per cycle.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE->RUN on Start_In=1: latch A, B and Carry_In into the carry register; byte index = 0.
REQ-015 RUN, each edge: slice computes byte[idx] of A+B+carry register; write result byte to working register; carry register <= slice carry; idx++.
REQ-016 RUN->DONE on the edge processing idx = NUM_BYTES-1; that edge SHALL copy the working register to Sum_Out and the slice carry to Carry_Out.
REQ-017 Done_Out SHALL be 1 only in DONE; DONE->RUN if Start_In=1 (accepted as in REQ-014), else DONE->IDLE.
REQ-018 Latency: for Start sampled at edge t, Busy_Out = 1 from t to t+NUM_BYTES, Done_Out = 1 for exactly one cycle after edge t+NUM_BYTES.
REQ-019 Start_In during RUN SHALL be ignored; operands and result SHALL be unaffected.
REQ-020 Operand inputs SHALL be don't-care except on the accepting edge.
REQ-021 Byte-index counter width SHALL be clog2(NUM_BYTES); the index SHALL NOT wrap during RUN.
REQ-022 Sum_Out/Carry_Out SHALL change only at the RUN->DONE edge or on reset.

Reset
REQ-023 Reset_n_In low SHALL immediately force IDLE, idx = 0, and every register and output (Busy_Out, Done_Out, Sum_Out, Carry_Out) to 0.
REQ-024 Reset during RUN SHALL abort the operation with no Done_Out pulse; the first Start after release SHALL operate normally.

Configuration
REQ-025 Macro ADDER_SEQ_SUBTRACT_EN defined: add port Sub_In (in, 1), captured on Start; when 1, B is bit-inverted and the initial carry forced to 1 (A-B); Carry_Out=1 means no borrow.
REQ-026 Macro undefined: no Sub_In port; addition only.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the byte-width constant 8.
REQ-028 Sub-module byte_cla_slice SHALL be the combinational 8-bit lookahead slice (A, B, carry in -> 8-bit sum, carry out), instantiated once.

Verification (NUM_BYTES = 4)
REQ-029 A=0x00000001, B=0xFFFFFFFF, Cin=0, Start at edge t -> Sum=0x00000000, Carry=1, Done after edge t+4, Busy high t..t+4.
REQ-030 A=0x12345678, B=0x11111111, Cin=1 -> Sum=0x2345678A, Carry=0.
REQ-031 Start with A=1, B=2; during RUN, Start with A=9, B=9 -> single Done, Sum=0x00000003.
REQ-032 Reset_n_In low after 2 RUN edges -> all outputs 0 at once, no Done; then A=B=0x80000000 -> Sum=0, Carry=1.
REQ-033 Start held high through the DONE cycle with new operands 0xFF, 0x01 -> second Done 4 edges later, Sum=0x00000100, Carry=0.
REQ-034 With ADDER_SEQ_SUBTRACT_EN: Sub_In=1, A=5, B=7 -> Sum=0xFFFFFFFE, Carry=0; A=7, B=5 -> Sum=0x00000002, Carry=1.
